round_controller: RTL and testbench

//  Control FSM for one game session; sits directly downstream of the seconds

---
 rtl/round_controller_pkg.sv | 25 ++
 rtl/round_controller_if.sv | 26 ++
 rtl/round_controller_tick_gen.sv | 28 ++
 rtl/round_controller.sv | 112 +++++++++++
 tb/tb_round_controller.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/round_controller_pkg.sv
// Shared types and constants for the game-session round controller.
package round_controller_pkg;

  localparam int unsigned TEMPO_W    = 4;
  localparam int unsigned ROUND_W    = 2;
  localparam int unsigned HITS_W     = 3;
  localparam int unsigned ROUNDS_DEF = 4;

  localparam logic [TEMPO_W-1:0] TIME_LIMIT_DEF = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_NEXT = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // Increment that sticks at the ceiling instead of wrapping.
  function automatic logic [HITS_W-1:0] sat_inc(input logic [HITS_W-1:0] v,
                                                input logic [HITS_W-1:0] ceil);
    return (v >= ceil) ? v : v + HITS_W'(1);
  endfunction

endpackage

// File: rtl/round_controller_if.sv
// Player/counter-facing signal bundle of the round controller.
interface round_controller_if;
  import round_controller_pkg::*;

  logic               start;
  logic               answer;
  logic [TEMPO_W-1:0] tempo;
  logic               end_time;
  logic               cnt_R;
  logic               cnt_E;
  logic [ROUND_W-1:0] round;
  logic [HITS_W-1:0]  hits;
  logic               timeout;
  logic               done;

  modport master (
    output start, answer, tempo, end_time,
    input  cnt_R, cnt_E, round, hits, timeout, done
  );

  modport slave (
    input  start, answer, tempo, end_time,
    output cnt_R, cnt_E, round, hits, timeout, done
  );

endinterface

// File: rtl/round_controller_tick_gen.sv
// Seconds prescaler: tick is high for one cycle every DIV clocks; clr holds it at zero.
module tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clkt,
  input  logic R,
  input  logic clr,
  output logic tick
);

  localparam int unsigned     CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clkt or posedge R) begin
    if (R) cnt_q <= '0;
    else   cnt_q <= cnt_d;
  end

endmodule

// File: rtl/round_controller.sv
// Session FSM: runs ROUNDS timed rounds against the seconds counter and tallies hits.
module round_controller
  import round_controller_pkg::*;
#(
  parameter int unsigned        CLK_HZ     = 50_000_000,
  parameter int unsigned        TICK_HZ    = 1,
  parameter int unsigned        ROUNDS     = ROUNDS_DEF,
  parameter logic [TEMPO_W-1:0] TIME_LIMIT = TIME_LIMIT_DEF
) (
  input  logic               clkt,
  input  logic               R,
  round_controller_if.slave  bus
);

  localparam int unsigned        DIV        = CLK_HZ / TICK_HZ;
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);
  localparam logic [HITS_W-1:0]  MAX_HITS   = HITS_W'(ROUNDS);

  state_e             state_q, state_d;
  logic               start_q;
  logic               cnt_r_q, cnt_r_d;
  logic               cnt_e_q, cnt_e_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [HITS_W-1:0]  hits_q, hits_d;
  logic               timeout_q, timeout_d;
  logic               done_q, done_d;

  logic start_rise_c, tick_c, to_c, presc_clr_c;

  assign start_rise_c = bus.start & ~start_q;
  assign presc_clr_c  = (state_q != S_RUN);
  assign to_c         = (tick_c & (bus.tempo == TIME_LIMIT)) | bus.end_time;

  tick_gen #(.DIV(DIV)) u_tick (
    .clkt (clkt),
    .R    (R),
    .clr  (presc_clr_c),
    .tick (tick_c)
  );

  // Next state and next register values; an answer beats a simultaneous timeout.
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    hits_d    = hits_q;
    timeout_d = 1'b0;
    cnt_e_d   = 1'b0;

    case (state_q)
      S_IDLE: if (start_rise_c) state_d = S_LOAD;
      S_LOAD: begin
        round_d = '0;
        hits_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // Enable is withheld on the timeout tick so the counter never wraps.
        cnt_e_d = tick_c & ~to_c;
        if (bus.answer) begin
          hits_d  = sat_inc(hits_q, MAX_HITS);
          state_d = S_NEXT;
        end else if (to_c) begin
          timeout_d = 1'b1;
          state_d   = S_NEXT;
        end
      end
      S_NEXT: begin
        if (round_q == LAST_ROUND) begin
          state_d = S_DONE;
        end else begin
          round_d = round_q + ROUND_W'(1);
          state_d = S_RUN;
        end
      end
      S_DONE: if (start_rise_c) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase

    cnt_r_d = (state_d != S_RUN);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clkt or posedge R) begin
    if (R) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      cnt_r_q   <= 1'b1;
      cnt_e_q   <= 1'b0;
      round_q   <= '0;
      hits_q    <= '0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= bus.start;
      cnt_r_q   <= cnt_r_d;
      cnt_e_q   <= cnt_e_d;
      round_q   <= round_d;
      hits_q    <= hits_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
    end
  end

  assign bus.cnt_R   = cnt_r_q;
  assign bus.cnt_E   = cnt_e_q;
  assign bus.round   = round_q;
  assign bus.hits    = hits_q;
  assign bus.timeout = timeout_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller with a seconds-counter model; round results go through a scoreboard.
module tb_round_controller;

  typedef struct packed {
    logic [1:0] round;
    logic [2:0] hits;
    logic       timeout;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] tempo = 4'd0;
  logic       et_force = 1'b0;
  logic       prev_cnt_r = 1'b1;

  int n_chk  = 0;
  int n_pass = 0;
  int m_round = 0;
  int m_hits  = 0;
  exp_t exp_q[$];

  round_controller_if bus();

  round_controller #(.CLK_HZ(10), .TICK_HZ(1)) dut (
    .clkt (clk),
    .R    (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Seconds counter: synchronous clear on cnt_R, count on cnt_E.
  always @(posedge clk) begin
    if (bus.cnt_R)      tempo <= 4'd0;
    else if (bus.cnt_E) tempo <= tempo + 4'd1;
  end

  assign bus.tempo    = tempo;
  assign bus.end_time = et_force | (tempo == 4'hF);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Each round end (cnt_R rising) is checked against the oldest scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_cnt_r = 1'b1;
    end else begin
      if (bus.cnt_R && !prev_cnt_r) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_round_end", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_round",   32'(bus.round),   32'(e.round));
          chk("sb_hits",    32'(bus.hits),    32'(e.hits));
          chk("sb_timeout", 32'(bus.timeout), 32'(e.timeout));
        end
      end
      prev_cnt_r = bus.cnt_R;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tempo(input logic [3:0] v, input string tag);
    int n = 0;
    while (bus.tempo != v && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(bus.tempo), 32'(v));
  endtask

  task automatic send_answer(input logic et);
    exp_t e;
    if (m_hits < 4) m_hits++;
    e.round   = 2'(m_round);
    e.hits    = 3'(m_hits);
    e.timeout = 1'b0;
    exp_q.push_back(e);
    bus.answer = 1'b1;
    et_force   = et;
    step(1);
    bus.answer = 1'b0;
    et_force   = 1'b0;
    step(1);
    if (m_round < 3) m_round++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin
    int n;
    exp_t e;
    rst = 1'b1;
    bus.start  = 1'b0;
    bus.answer = 1'b0;
    step(2);
    chk("rst_cnt_r",   32'(bus.cnt_R),   32'd1);
    chk("rst_cnt_e",   32'(bus.cnt_E),   32'd0);
    chk("rst_round",   32'(bus.round),   32'd0);
    chk("rst_hits",    32'(bus.hits),    32'd0);
    chk("rst_timeout", 32'(bus.timeout), 32'd0);
    chk("rst_done",    32'(bus.done),    32'd0);
    #2 rst = 1'b0;
    step(1);

    // Start edge: LOAD next cycle, RUN two cycles after the edge.
    bus.start = 1'b1;
    step(1);
    chk("load_cnt_r", 32'(bus.cnt_R), 32'd1);
    step(1);
    chk("run_cnt_r", 32'(bus.cnt_R), 32'd0);
    chk("run_round", 32'(bus.round), 32'd0);
    chk("run_hits",  32'(bus.hits),  32'd0);
    bus.start = 1'b0;

    // Round 0 answered at tempo 3.
    wait_tempo(4'd3, "r0_tempo3");
    send_answer(1'b0);
    chk("r1_round",   32'(bus.round),   32'd1);
    chk("r1_tempo",   32'(bus.tempo),   32'd0);
    chk("r1_timeout", 32'(bus.timeout), 32'd0);
    chk("r1_cnt_r",   32'(bus.cnt_R),   32'd0);

    // Round 1 left to time out.
    n = 0;
    while (!bus.cnt_E && n < 50) begin step(1); n++; end
    chk("r1_first_cnt_e", 32'(n), 32'd10);
    n = 0;
    do begin step(1); n++; end while (!bus.cnt_E && n < 50);
    chk("r1_cnt_e_period", 32'(n), 32'd10);
    e.round = 2'(m_round); e.hits = 3'(m_hits); e.timeout = 1'b1;
    exp_q.push_back(e);
    wait_tempo(4'd9, "r1_tempo9");
    n = 0;
    while (!bus.timeout && n < 50) begin step(1); n++; end
    chk("r1_timeout_latency", 32'(n), 32'd9);
    chk("r1_no_wrap", 32'(bus.tempo), 32'd9);
    step(1);
    m_round++;
    chk("r1_timeout_pulse", 32'(bus.timeout), 32'd0);
    chk("r2_tempo",         32'(bus.tempo),   32'd0);
    chk("r2_round",         32'(bus.round),   32'(m_round));

    // Round 2: answer coincides with the terminal flag.
    wait_tempo(4'd2, "r2_tempo2");
    send_answer(1'b1);
    chk("r3_round",   32'(bus.round),   32'd3);
    chk("r3_timeout", 32'(bus.timeout), 32'd0);

    // Round 3 answered; session completes.
    wait_tempo(4'd1, "r3_tempo1");
    send_answer(1'b0);
    chk("done_done",  32'(bus.done),  32'd1);
    chk("done_hits",  32'(bus.hits),  32'd3);
    chk("done_round", 32'(bus.round), 32'd3);
    chk("done_cnt_r", 32'(bus.cnt_R), 32'd1);
    bus.answer = 1'b1;
    step(1);
    bus.answer = 1'b0;
    step(1);
    chk("done_answer_ignored", 32'(bus.hits), 32'd3);
    chk("done_hold",           32'(bus.done), 32'd1);

    // Restart from DONE.
    bus.start = 1'b1;
    step(1);
    chk("restart_load_done", 32'(bus.done), 32'd0);
    step(1);
    bus.start = 1'b0;
    m_round = 0;
    m_hits  = 0;
    chk("restart_hits",  32'(bus.hits),  32'd0);
    chk("restart_round", 32'(bus.round), 32'd0);
    chk("restart_cnt_r", 32'(bus.cnt_R), 32'd0);

    wait_tempo(4'd2, "s2_tempo2");
    send_answer(1'b0);
    chk("s2_round1", 32'(bus.round), 32'd1);

    // Asynchronous reset in the middle of a round.
    wait_tempo(4'd5, "s2_tempo5");
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cnt_r",   32'(bus.cnt_R),   32'd1);
    chk("mid_rst_round",   32'(bus.round),   32'd0);
    chk("mid_rst_hits",    32'(bus.hits),    32'd0);
    chk("mid_rst_timeout", 32'(bus.timeout), 32'd0);
    step(1);
    #2 rst = 1'b0;
    step(1);
    chk("post_rst_tempo",   32'(bus.tempo),   32'd0);
    chk("post_rst_timeout", 32'(bus.timeout), 32'd0);
    step(3);
    chk("post_rst_idle", 32'(bus.cnt_R), 32'd1);
    chk("post_rst_done", 32'(bus.done),  32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
